// File: rtl/unisim_sram_b_rd_stream.sv
// Streaming read front-end for the 1w:1r sram_b wrappers: valid/ready requests become
// CE1/A1 strobes, and Q1 is captured into a credit-protected response buffer.
module unisim_sram_b_rd_stream #(
  parameter int unsigned ABITS = 15,
  parameter int unsigned DBITS = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ABITS-1:0] req_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DBITS-1:0] rsp_data,
  output logic             idle,
  output logic             CE1,
  output logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] Q1
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  logic             inflight;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DBITS-1:0] mem [DEPTH];
  logic [CW:0]      credits_used;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // The in-flight read already owns a slot, so credits depend only on registered state.
  always_comb begin
    credits_used = {1'b0, cnt} + {{CW{1'b0}}, inflight};
    req_ready    = !RST && (credits_used < DEPTH_EXT);
    CE1          = req_valid && req_ready;
    A1           = req_addr;
    rsp_valid    = (cnt != '0);
    rsp_data     = mem[rd_ptr];
    idle         = (cnt == '0) && !inflight;
    push         = inflight;
    pop          = rsp_valid && rsp_ready;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight <= 1'b0;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= CE1;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Read in flight during reset is dropped rather than written.
  always_ff @(posedge CLK) begin
    if (!RST && push) mem[wr_ptr] <= Q1;
  end

  a_no_push_at_full: assert property (@(posedge CLK) disable iff (RST)
    !(push && (cnt == DEPTH_CNT)));

endmodule

// File: tb/tb_unisim_sram_b_rd_stream.sv
// Scoreboard bench for unisim_sram_b_rd_stream: a DEPTH=3 instance for the main tests
// and a DEPTH=2 instance for the reduced-throughput build.
module tb_unisim_sram_b_rd_stream;

  localparam int unsigned AB = 15;
  localparam int unsigned DB = 8;
  localparam int unsigned D1 = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, idle, CE1;
  logic [AB-1:0] req_addr = '0, A1;
  logic [DB-1:0] rsp_data, Q1;

  logic          rv2 = 1'b0, rr2, sv2, sr2 = 1'b0, idle2, ce2;
  logic [AB-1:0] ra2 = '0, a2;
  logic [DB-1:0] sd2, q2;

  logic [DB-1:0] sram [1 << AB];
  logic [DB-1:0] q[$];
  logic [DB-1:0] q2s[$];
  int            checks = 0;
  int            failures = 0;
  int            max_occ = 0;

  always #5 CLK = ~CLK;

  unisim_sram_b_rd_stream #(.ABITS(AB), .DBITS(DB), .DEPTH(D1)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .idle(idle), .CE1(CE1), .A1(A1), .Q1(Q1));

  unisim_sram_b_rd_stream #(.ABITS(AB), .DBITS(DB), .DEPTH(2)) dut2 (
    .CLK(CLK), .RST(RST), .req_valid(rv2), .req_ready(rr2),
    .req_addr(ra2), .rsp_valid(sv2), .rsp_ready(sr2),
    .rsp_data(sd2), .idle(idle2), .CE1(ce2), .A1(a2), .Q1(q2));

  // Synchronous SRAM read ports: data one cycle after CE1.
  always @(posedge CLK) begin
    if (CE1) Q1 <= sram[A1];
    if (ce2) q2 <= sram[a2];
  end

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string name);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: compare the buffer head whenever a response is presented.
  always @(negedge CLK) begin
    if (RST) begin
      q.delete();
    end else begin
      if (rsp_valid) begin
        if (q.size() == 0) chk(32'(rsp_valid), 32'd0, "rsp_unexpected");
        else begin
          chk(32'(rsp_data), 32'(q[0]), "rsp_data");
          if (rsp_ready) void'(q.pop_front());
        end
      end
      if (req_valid && req_ready) q.push_back(sram[req_addr]);
      if (q.size() > max_occ) max_occ = q.size();
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      q2s.delete();
    end else begin
      if (sv2) begin
        if (q2s.size() == 0) chk(32'(sv2), 32'd0, "rsp2_unexpected");
        else begin
          chk(32'(sd2), 32'(q2s[0]), "rsp2_data");
          if (sr2) void'(q2s.pop_front());
        end
      end
      if (rv2 && rr2) q2s.push_back(sram[ra2]);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      @(negedge CLK);
      if (idle && q.size() == 0) done = 1'b1;
    end
    chk(32'(done), 32'd1, name);
  endtask

  task automatic stream(input int n, input bit bank, input string name);
    bit all_ready = 1'b1;
    int vcnt = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      step();
      req_valid = (i < n);
      if (bank) req_addr = (i % 2 == 0) ? 15'h3FFF : 15'h4000;
      else      req_addr = AB'(i);
      @(negedge CLK);
      if (i < n && !req_ready) all_ready = 1'b0;
      if (rsp_valid) vcnt++;
    end
    chk(32'(all_ready), 32'd1, {name, "_req_ready"});
    chk(32'(vcnt), 32'(n), {name, "_rsp_consecutive"});
    wait_idle({name, "_idle"});
  endtask

  initial begin
    int acc;
    int cyc;

    for (int unsigned a = 0; a < (1 << AB); a++) sram[a] = 8'(a) ^ 8'h5A;
    sram[15'h0010] = 8'hA5;
    sram[15'h3FFF] = 8'h11;
    sram[15'h4000] = 8'h22;

    // Reset state, with a request already pending.
    req_valid = 1'b1;
    repeat (3) step();
    @(negedge CLK);
    chk(32'(req_ready), 32'd0, "rst_req_ready");
    chk(32'(CE1), 32'd0, "rst_ce1");
    chk(32'(rsp_valid), 32'd0, "rst_rsp_valid");
    chk(32'(idle), 32'd1, "rst_idle");
    step();
    RST = 1'b0;
    req_valid = 1'b0;
    @(negedge CLK);
    chk(32'(req_ready), 32'd1, "post_rst_req_ready");

    // Single read and its latency.
    step();
    req_valid = 1'b1; req_addr = 15'h0010; rsp_ready = 1'b1;
    @(negedge CLK);
    chk(32'(CE1), 32'd1, "t1_ce1");
    chk(32'(A1), 32'h0010, "t1_a1");
    step();
    req_valid = 1'b0;
    @(negedge CLK);
    chk(32'(rsp_valid), 32'd0, "t1_rsp_valid_t1");
    step();
    @(negedge CLK);
    chk(32'(rsp_valid), 32'd1, "t1_rsp_valid_t2");
    chk(32'(rsp_data), 32'hA5, "t1_rsp_data_t2");
    step();
    @(negedge CLK);
    chk(32'(idle), 32'd1, "t1_idle_t3");

    stream(16, 1'b0, "t2");

    // Backpressure: three credits, then stall with the head held.
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      req_valid = 1'b1; req_addr = AB'(32'h20 + i);
      @(negedge CLK);
      if (req_valid && req_ready) acc++;
    end
    chk(32'(acc), 32'd3, "t3_accepts");
    chk(32'(req_ready), 32'd0, "t3_req_ready_full");
    step();
    req_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle("t3_drain");

    // Random valid/ready traffic.
    acc = 0; cyc = 0; max_occ = 0;
    while (acc < 200 && cyc < 3000) begin
      step();
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = 1'($urandom_range(0, 1));
      req_addr  = AB'($urandom_range(0, (1 << AB) - 1));
      @(negedge CLK);
      if (req_valid && req_ready) acc++;
      cyc++;
    end
    chk(32'(acc), 32'd200, "t4_accepts");
    step();
    req_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle("t4_drain");
    chk(32'(max_occ <= int'(D1)), 32'd1, "t4_max_occupancy");

    stream(8, 1'b1, "t5");

    // Reset with two buffered and one in flight.
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      req_valid = 1'b1; req_addr = AB'(32'h30 + i);
      @(negedge CLK);
      if (req_valid && req_ready) acc++;
    end
    chk(32'(acc), 32'd3, "t6_accepts");
    step();
    req_valid = 1'b0; RST = 1'b1;
    step();
    RST = 1'b0; req_valid = 1'b1; req_addr = 15'h0010; rsp_ready = 1'b1;
    @(negedge CLK);
    chk(32'(rsp_valid), 32'd0, "t6_rsp_valid_after_rst");
    chk(32'(idle), 32'd1, "t6_idle_after_rst");
    chk(32'(req_ready), 32'd1, "t6_req_ready_after_rst");
    step();
    req_valid = 1'b0;
    step();
    @(negedge CLK);
    chk(32'(rsp_valid), 32'd1, "t6_rsp_valid_t2");
    chk(32'(rsp_data), 32'hA5, "t6_rsp_data_t2");
    wait_idle("t6_idle");

    // DEPTH=2 instance: two accepts every three cycles.
    sr2 = 1'b1;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      rv2 = 1'b1; ra2 = AB'(32'h40 + i);
      @(negedge CLK);
      if (rv2 && rr2) acc++;
    end
    chk(32'(acc), 32'd8, "t7_accepts");
    step();
    rv2 = 1'b0;
    repeat (4) step();
    @(negedge CLK);
    chk(32'(idle2 && q2s.size() == 0), 32'd1, "t7_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
